apu_sample_fifo: RTL and testbench
==================================

Name: apu_sample_fifo

Overview:
- Buffers 16-bit mono PCM samples from the APU mixer and releases exactly one sample per I2S frame to the I2S serializer.
- Sits directly upstream of the I2S output stage and drives its `sample` input.
- Runs in the same 1.024 MHz audio clock domain, so no CDC is needed.
- Each output sample is held stable for a full frame, so the serializer's latch instant within the frame does not matter.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- FRAME_LEN, 32, audio clocks per output sample (16 bits × 2 word-select halves at 1.024 MHz gives 32 kHz).
- LOW_WATER, 4, level threshold used by the optional IRQ.

Ports:
- clock  in  1  1.024 MHz audio clock; all state updates on posedge.
- reset_l  in  1  reset, asynchronous, active-low.
- enable  in  1  playback enable; when low, no pops occur.
- wr_data  in  16  sample from mixer (two's complement).
- wr_valid  in  1  wr_data valid.
- wr_ready  out  1  FIFO can accept a write.
- sample  out  16  current output sample to the I2S serializer; registered.
- frame_tick  out  1  one-cycle pulse on the cycle the pop decision is made.
- level  out  $clog2(DEPTH)+1  number of stored entries.
- underrun  out  1  sticky underrun flag.
- underrun_clr  in  1  clears underrun.
- irq  out  1  present only with the optional feature.

Behaviour:
- Reset values: sample=0, level=0, underrun=0, frame_tick=0, irq=0. Internal state: frame counter=0, read/write pointers=0.
- wr_ready = (level != DEPTH); combinational from registered level. Full means not ready, even if a pop occurs in the same cycle.
- A write occurs when wr_valid && wr_ready. The entry is stored at the write pointer and the pointer increments, wrapping modulo DEPTH.
- frame_cnt counts 0..FRAME_LEN-1 and wraps to 0 while enable=1.
- While enable=0: frame_cnt is held at 0, there are no pops or underruns, and sample is registered to 0 on the next clock. Writes are still accepted.
- Pop decision happens when enable && frame_cnt==FRAME_LEN-1; frame_tick=1 on that cycle (combinational from frame_cnt and enable).
  - If level>0: sample <= head entry, read pointer increments (wrapping), level decrements.
  - If level==0: sample <= 16'h0000 and underrun <= 1.
  - The new sample is visible on the clock after frame_tick and is held for FRAME_LEN cycles.
- Simultaneous write and pop:
  - Non-empty FIFO: level is unchanged; the data read is the old head.
  - Empty FIFO (level==0): the pop is an underrun, the write is stored, and level becomes 1.
- Latency: a write at cycle t is reflected in level at t+1. It reaches `sample` at the first pop boundary after t+1 for which it is the head.
- underrun: if underrun_clr and a new underrun occur in the same cycle, set wins. Otherwise underrun_clr clears the flag on the next clock.
- level arithmetic: next_level = level + wr_fire - pop_fire; it never exceeds DEPTH and never goes below 0.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronous). Stored samples are discarded, and the first pop after release happens FRAME_LEN cycles after the first enabled clock.
- Enable deasserted mid-frame: the partial frame is discarded, and re-enable restarts a full FRAME_LEN count.

Optional Feature:
- Macro: APU_SAMPLE_FIFO_IRQ_EN.
- Defined:
  - irq is a registered level: irq <= enable && (level <= LOW_WATER).
  - It is recomputed each cycle from the current level (one-cycle lag), which requests the mixer to refill.
- Undefined: the irq port is absent and no comparator logic is built.

Test Plan:
- Reset then enable=1, no writes → `sample` stays 0, frame_tick pulses every 32 cycles, underrun=1 after the first tick, level stays 0.
- Write 16'h1234, 16'hABCD, 16'h8000 back-to-back, enable=1 → `sample` shows 1234, ABCD, 8000 on successive 32-cycle frames, then 0000 with underrun set. Pulse underrun_clr → underrun=0.
- Write 16 entries (DEPTH=16) with enable=0 → wr_ready=0 and level=16; a 17th write is ignored. Enable → the first pop makes level=15 and wr_ready=1 on the next cycle.
- Empty FIFO, write on the frame_tick cycle → underrun set, level=1, and the written value appears on `sample` at the next frame.
- Fill 5 entries, pulse reset_l low mid-frame → level=0, sample=0, underrun=0; after release, the first pop occurs 32 enabled cycles later.
- With APU_SAMPLE_FIFO_IRQ_EN, LOW_WATER=4: fill 6 entries, enable → irq=0 until level drops to 4, then irq=1 one cycle later; write 1 entry → irq=0 one cycle after level reaches 5.

Source files
------------

// File: rtl/apu_sample_fifo.sv
// Sample FIFO between the APU mixer and the I2S serializer: releases one 16-bit sample per frame.
// Optional low-water interrupt output is built when APU_SAMPLE_FIFO_IRQ_EN is defined.
module apu_sample_fifo #(
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 32,
    parameter int LOW_WATER = 4
) (
    input  logic                       clock,
    input  logic                       reset_l,
    input  logic                       enable,
    input  logic [15:0]                wr_data,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    output logic [15:0]                sample,
    output logic                       frame_tick,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       underrun,
    input  logic                       underrun_clr
`ifdef APU_SAMPLE_FIFO_IRQ_EN
    ,
    output logic                       irq
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [CW-1:0] frame_cnt_q, frame_cnt_d;
    logic [15:0]   sample_q, sample_d;
    logic          underrun_q, underrun_d;
    logic          wr_fire, pop_fire, underrun_set;

    assign wr_ready     = (level_q != LW'(DEPTH));
    assign frame_tick   = enable && (frame_cnt_q == CW'(FRAME_LEN - 1));
    assign wr_fire      = wr_valid && wr_ready;
    assign pop_fire     = frame_tick && (level_q != '0);
    assign underrun_set = frame_tick && (level_q == '0);

    always_comb begin
        wr_ptr_d    = wr_fire  ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop_fire ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d     = level_q + LW'(wr_fire) - LW'(pop_fire);
        frame_cnt_d = '0;
        sample_d    = sample_q;
        underrun_d  = underrun_q;

        // A disabled stream discards the partial frame and mutes the output.
        if (!enable) begin
            sample_d = '0;
        end else begin
            if (!frame_tick) begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
            if (pop_fire) begin
                sample_d = mem_q[rd_ptr_q];
            end else if (underrun_set) begin
                sample_d = '0;
            end
        end

        if (underrun_set) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            frame_cnt_q <= '0;
            sample_q    <= '0;
            underrun_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            frame_cnt_q <= frame_cnt_d;
            sample_q    <= sample_d;
            underrun_q  <= underrun_d;
        end
    end

    // Storage is not reset; level alone decides which entries are meaningful.
    always_ff @(posedge clock) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign sample   = sample_q;
    assign level    = level_q;
    assign underrun = underrun_q;

`ifdef APU_SAMPLE_FIFO_IRQ_EN
    logic irq_q;

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= enable && (level_q <= LW'(LOW_WATER));
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_apu_sample_fifo.sv
// Randomized and directed bench for apu_sample_fifo against a queue-based frame model.
module tb_apu_sample_fifo;

    localparam int DEPTH     = 16;
    localparam int FRAME_LEN = 32;
    localparam int LOW_WATER = 4;

    logic        clock = 1'b0;
    logic        reset_l = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] sample;
    logic        frame_tick;
    logic [4:0]  level;
    logic        underrun;
    logic        underrun_clr = 1'b0;
`ifdef APU_SAMPLE_FIFO_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: contents as a queue, position within the frame as an integer.
    logic [15:0] mq[$];
    int          mCnt = 0;
    logic [15:0] mSample = '0;
    logic        mUr = 1'b0;
    logic        mIrq = 1'b0;
    logic        expTick;
    logic        tickObs;

    apu_sample_fifo #(.DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN), .LOW_WATER(LOW_WATER)) dut (
        .clock(clock),
        .reset_l(reset_l),
        .enable(enable),
        .wr_data(wr_data),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .sample(sample),
        .frame_tick(frame_tick),
        .level(level),
        .underrun(underrun),
        .underrun_clr(underrun_clr)
`ifdef APU_SAMPLE_FIFO_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    always #5 clock = ~clock;

    task automatic modelClear();
        mq.delete();
        mCnt = 0;
        mSample = '0;
        mUr = 1'b0;
        mIrq = 1'b0;
    endtask

    // Drives one clock cycle, records the observed frame_tick and advances the model.
    task automatic step(input logic en, input logic wv, input logic [15:0] wd, input logic clr);
        logic wf;
        enable = en;
        wr_valid = wv;
        wr_data = wd;
        underrun_clr = clr;
        #1;
        tickObs = frame_tick;
        expTick = en && (mCnt == FRAME_LEN - 1);
        wf = wv && (mq.size() < DEPTH);
        mIrq = en && (mq.size() <= LOW_WATER);
        if (expTick) begin
            if (mq.size() > 0) begin
                mSample = mq.pop_front();
            end else begin
                mSample = '0;
                mUr = 1'b1;
            end
        end else if (clr) begin
            mUr = 1'b0;
        end
        if (wf) mq.push_back(wd);
        if (!en) begin
            mSample = '0;
            mCnt = 0;
        end else begin
            mCnt = expTick ? 0 : mCnt + 1;
        end
        @(posedge clock);
        #2;
    endtask

    task automatic doReset();
        reset_l = 1'b0;
        enable = 1'b0;
        wr_valid = 1'b0;
        underrun_clr = 1'b0;
        modelClear();
        @(posedge clock);
        #2;
        reset_l = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (sample !== 16'h0000) begin errors++; $display("[TB] FAIL reset_sample got %h want 0000", sample); end
        checks++;
        if (level !== 5'd0) begin errors++; $display("[TB] FAIL reset_level got %0d want 0", level); end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_underrun got %b want 0", underrun); end
        checks++;
        if (frame_tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick got %b want 0", frame_tick); end
        checks++;
        if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_wr_ready got %b want 1", wr_ready); end
        @(posedge clock);
        #2;
        reset_l = 1'b1;
    endtask

    task automatic test_idle_underrun();
        int ticks = 0;
        for (int i = 0; i < 3 * FRAME_LEN; i++) begin
            step(1'b1, 1'b0, 16'h0, 1'b0);
            checks++;
            if (tickObs !== ((i % FRAME_LEN) == FRAME_LEN - 1)) begin
                errors++; $display("[TB] FAIL idle_tick cycle %0d got %b", i, tickObs);
            end
            if (tickObs) ticks++;
            checks++;
            if (sample !== 16'h0000 || level !== 5'd0) begin
                errors++; $display("[TB] FAIL idle_out got sample %h level %0d want 0000 0", sample, level);
            end
            if (i == FRAME_LEN - 2 || i == FRAME_LEN - 1) begin
                checks++;
                if (underrun !== (i == FRAME_LEN - 1)) begin
                    errors++; $display("[TB] FAIL idle_underrun cycle %0d got %b", i, underrun);
                end
            end
        end
        checks++;
        if (ticks != 3) begin errors++; $display("[TB] FAIL idle_tick_count got %0d want 3", ticks); end
        step(1'b0, 1'b0, 16'h0, 1'b1);
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL idle_clr got %b want 0", underrun); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [4];
        vals[0] = 16'h1234; vals[1] = 16'hABCD; vals[2] = 16'h8000; vals[3] = 16'h0000;
        for (int i = 0; i < 4 * FRAME_LEN; i++) begin
            step(1'b1, i < 3, (i < 3) ? vals[i] : 16'h0, 1'b0);
            if (i % FRAME_LEN == FRAME_LEN - 1) begin
                checks++;
                if (sample !== vals[i / FRAME_LEN]) begin
                    errors++; $display("[TB] FAIL b2b_sample frame %0d got %h want %h", i / FRAME_LEN, sample, vals[i / FRAME_LEN]);
                end
                checks++;
                if (underrun !== (i / FRAME_LEN == 3)) begin
                    errors++; $display("[TB] FAIL b2b_underrun frame %0d got %b", i / FRAME_LEN, underrun);
                end
            end else if (i > FRAME_LEN) begin
                checks++;
                if (sample !== mSample) begin
                    errors++; $display("[TB] FAIL b2b_hold cycle %0d got %h want %h", i, sample, mSample);
                end
            end
        end
        step(1'b0, 1'b0, 16'h0, 1'b1);
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL b2b_clr got %b want 0", underrun); end
    endtask

    task automatic test_full();
        logic [15:0] first;
        first = 16'(100);
        for (int i = 0; i < DEPTH + 1; i++) begin
            step(1'b0, 1'b1, 16'(100 + i), 1'b0);
        end
        checks++;
        if (level !== 5'd16 || wr_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL full_state got level %0d ready %b want 16 0", level, wr_ready);
        end
        for (int i = 0; i < FRAME_LEN; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
        checks++;
        if (level !== 5'd15 || wr_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL full_pop got level %0d ready %b want 15 1", level, wr_ready);
        end
        checks++;
        if (sample !== first) begin errors++; $display("[TB] FAIL full_head got %h want %h", sample, first); end
    endtask

    task automatic test_write_on_tick();
        doReset();
        for (int i = 0; i < FRAME_LEN - 1; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b1, 16'h5A5A, 1'b0);
        checks++;
        if (tickObs !== 1'b1) begin errors++; $display("[TB] FAIL wot_tick got %b want 1", tickObs); end
        checks++;
        if (underrun !== 1'b1 || level !== 5'd1 || sample !== 16'h0) begin
            errors++; $display("[TB] FAIL wot_state got ur %b level %0d sample %h want 1 1 0000", underrun, level, sample);
        end
        for (int i = 0; i < FRAME_LEN; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
        checks++;
        if (sample !== 16'h5A5A || level !== 5'd0) begin
            errors++; $display("[TB] FAIL wot_sample got %h level %0d want 5a5a 0", sample, level);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'(16'hC000 + i), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
        #1;
        reset_l = 1'b0;
        modelClear();
        #1;
        checks++;
        if (level !== 5'd0 || sample !== 16'h0 || underrun !== 1'b0) begin
            errors++; $display("[TB] FAIL rmf_async got level %0d sample %h ur %b want 0 0000 0", level, sample, underrun);
        end
        @(posedge clock);
        #2;
        reset_l = 1'b1;
        n = 0;
        do begin
            step(1'b1, 1'b0, 16'h0, 1'b0);
            n++;
        end while (!tickObs && n < 4 * FRAME_LEN);
        checks++;
        if (n != FRAME_LEN) begin errors++; $display("[TB] FAIL rmf_first_pop got %0d want %0d", n, FRAME_LEN); end
    endtask

    task automatic test_random();
        doReset();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 19) != 0), ($urandom_range(0, 2) == 0), 16'($urandom), ($urandom_range(0, 29) == 0));
            checks++;
            if (tickObs !== expTick) begin errors++; $display("[TB] FAIL rnd_tick cycle %0d got %b want %b", i, tickObs, expTick); end
            checks++;
            if (sample !== mSample) begin errors++; $display("[TB] FAIL rnd_sample cycle %0d got %h want %h", i, sample, mSample); end
            checks++;
            if (level !== 5'(mq.size())) begin errors++; $display("[TB] FAIL rnd_level cycle %0d got %0d want %0d", i, level, mq.size()); end
            checks++;
            if (underrun !== mUr) begin errors++; $display("[TB] FAIL rnd_underrun cycle %0d got %b want %b", i, underrun, mUr); end
            checks++;
            if (wr_ready !== (mq.size() != DEPTH)) begin errors++; $display("[TB] FAIL rnd_wr_ready cycle %0d got %b", i, wr_ready); end
`ifdef APU_SAMPLE_FIFO_IRQ_EN
            checks++;
            if (irq !== mIrq) begin errors++; $display("[TB] FAIL rnd_irq cycle %0d got %b want %b", i, irq, mIrq); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_idle_underrun();
        test_back_to_back();
        test_full();
        test_write_on_tick();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
